// File: rtl/vector_load_store_unit.sv
// Serialises one scalar or vector load/store into LANES word accesses on a
// single synchronous data-memory port and assembles the loaded lanes.
module vector_load_store_unit #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic                      req_write,
  input  logic                      req_vector,
  input  logic                      req_strided,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W-1:0]         stride,
  input  logic [LANES*DATA_W-1:0]   in_writedata,
  input  logic [DATA_W-1:0]         in_readdata,
  output logic                      stall,
  output logic                      busy,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [DATA_W-1:0]         mem_writedata,
  output logic [LANES*DATA_W-1:0]   out_readdata
);

  localparam int unsigned IDX_W = $clog2(LANES);
  localparam int unsigned STEP  = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t             state;
  state_t             next_state;
  logic [IDX_W-1:0]   issue_idx;
  logic [IDX_W-1:0]   last_idx;
  logic [IDX_W-1:0]   cur_idx;
  logic [IDX_W-1:0]   req_last;
  logic [RD_LAT-1:0]  pipe_valid;
  logic [IDX_W-1:0]   pipe_idx [RD_LAT];
  logic               accept;
  logic               issuing;
  logic               issue_done;
  logic               cap_valid;
  logic               cap_last;
  logic [ADDR_W-1:0]  step;

  assign accept     = (state == IDLE) && req_valid && !reset;
  assign issuing    = accept || ((state == ISSUE) && !reset);
  assign req_last   = req_vector ? IDX_W'(LANES - 1) : '0;
  assign cur_idx    = (state == ISSUE) ? issue_idx : '0;
  assign issue_done = issuing && (cur_idx == req_last);
  assign cap_valid  = pipe_valid[RD_LAT-1];
  assign cap_last   = cap_valid && (pipe_idx[RD_LAT-1] == last_idx);

  // Scalar ops always use lane 0, so stride only matters for vectors.
  assign step          = (req_vector && req_strided) ? stride : ADDR_W'(STEP);
  assign mem_addr      = base_addr + ADDR_W'(ADDR_W'(cur_idx) * step);
  assign mem_read      = issuing && !req_write;
  assign mem_write     = issuing && req_write;
  assign mem_writedata = in_writedata[32'(cur_idx) * DATA_W +: DATA_W];

  // Stall falls on the op's final cycle: last store issue or last load capture.
  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    stall = req_valid && (!req_write || req_vector);
        ISSUE:   stall = !req_write || (issue_idx != req_last);
        DRAIN:   stall = !cap_last;
        default: stall = 1'b0;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_last != '0) next_state = ISSUE;
          else if (!req_write) next_state = DRAIN;
          else next_state = IDLE;
        end
      end
      ISSUE:   if (issue_done) next_state = req_write ? IDLE : DRAIN;
      DRAIN:   if (cap_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      issue_idx    <= '0;
      last_idx     <= '0;
      pipe_valid   <= '0;
      out_readdata <= '0;
      for (int s = 0; s < RD_LAT; s++) pipe_idx[s] <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);

      // Capture pipeline tracks which lane each outstanding read belongs to.
      pipe_valid[0] <= mem_read;
      pipe_idx[0]   <= cur_idx;
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_idx[s]   <= pipe_idx[s-1];
      end

      if (accept) begin
        last_idx <= req_last;
        if (!req_write) out_readdata <= '0;
      end
      if (cap_valid)
        out_readdata[32'(pipe_idx[RD_LAT-1]) * DATA_W +: DATA_W] <= in_readdata;

      if (state == ISSUE) begin
        issue_idx <= issue_done ? '0 : IDX_W'(issue_idx + 1'b1);
      end else if (accept) begin
        issue_idx <= (req_last != '0) ? IDX_W'(1) : '0;
      end
    end
  end

endmodule

// File: tb/tb_vector_load_store_unit.sv
// Directed and random checks of vector_load_store_unit at RD_LAT=1 and RD_LAT=2
// against an arithmetic reference of the access, stall and result rules.
module tb_vector_load_store_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid [2];
  logic         req_write;
  logic         req_vector;
  logic         req_strided;
  logic [31:0]  base_addr;
  logic [31:0]  stride;
  logic [127:0] in_writedata;
  logic [31:0]  rd0, rd1, rd1_a;
  logic         stall [2];
  logic         busy [2];
  logic [31:0]  maddr [2];
  logic         mread [2];
  logic         mwrite [2];
  logic [31:0]  mwdata [2];
  logic [127:0] rdout [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vector_load_store_unit #(.LANES(4), .DATA_W(32), .ADDR_W(32), .RD_LAT(1)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_write(req_write),
    .req_vector(req_vector), .req_strided(req_strided), .base_addr(base_addr),
    .stride(stride), .in_writedata(in_writedata), .in_readdata(rd0),
    .stall(stall[0]), .busy(busy[0]), .mem_addr(maddr[0]), .mem_read(mread[0]),
    .mem_write(mwrite[0]), .mem_writedata(mwdata[0]), .out_readdata(rdout[0]));

  vector_load_store_unit #(.LANES(4), .DATA_W(32), .ADDR_W(32), .RD_LAT(2)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_write(req_write),
    .req_vector(req_vector), .req_strided(req_strided), .base_addr(base_addr),
    .stride(stride), .in_writedata(in_writedata), .in_readdata(rd1),
    .stall(stall[1]), .busy(busy[1]), .mem_addr(maddr[1]), .mem_read(mread[1]),
    .mem_write(mwrite[1]), .mem_writedata(mwdata[1]), .out_readdata(rdout[1]));

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A5A5A;
  endfunction

  // Memory models: data valid RD_LAT cycles after the strobe, garbage otherwise.
  always @(posedge clk) begin
    rd0   <= mread[0] ? word(maddr[0]) : $urandom;
    rd1_a <= mread[1] ? word(maddr[1]) : $urandom;
    rd1   <= rd1_a;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one op on DUT d and checks every cycle plus the result visible afterwards.
  task automatic run_op(input int d, input bit wr, input bit vec, input bit strd,
                        input logic [31:0] base, input logic [31:0] strv,
                        input logic [127:0] wd);
    int n, lat, fin;
    logic [31:0]  stp;
    logic [31:0]  a;
    logic [127:0] exp_vec;
    n   = vec ? 4 : 1;
    lat = (d == 1) ? 2 : 1;
    stp = (vec && strd) ? strv : 32'd4;
    fin = wr ? n - 1 : n - 1 + lat;
    exp_vec = '0;
    @(posedge clk); #1;
    req_write = wr; req_vector = vec; req_strided = strd;
    base_addr = base; stride = strv; in_writedata = wd;
    req_valid[d] = 1'b1;
    for (int t = 0; t <= fin; t++) begin
      @(negedge clk);
      a = base + 32'(t) * stp;
      chk($sformatf("d%0d_rd_t%0d", d, t), 128'(mread[d]), 128'(t < n && !wr));
      chk($sformatf("d%0d_wr_t%0d", d, t), 128'(mwrite[d]), 128'(t < n && wr));
      if (t < n) chk($sformatf("d%0d_addr_t%0d", d, t), 128'(maddr[d]), 128'(a));
      if (t < n && wr) chk($sformatf("d%0d_wdata_t%0d", d, t), 128'(mwdata[d]), 128'(wd[t*32 +: 32]));
      if (t < n) exp_vec[t*32 +: 32] = word(a);
      chk($sformatf("d%0d_stall_t%0d", d, t), 128'(stall[d]), 128'(t != fin));
      @(posedge clk);
    end
    #1 req_valid[d] = 1'b0;
    @(negedge clk);
    chk($sformatf("d%0d_busy_after", d), 128'(busy[d]), 128'(0));
    chk($sformatf("d%0d_stall_after", d), 128'(stall[d]), 128'(0));
    if (!wr) chk($sformatf("d%0d_result", d), rdout[d], exp_vec);
  endtask

  initial begin
    reset = 1'b1;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    req_write = 1'b0; req_vector = 1'b0; req_strided = 1'b0;
    base_addr = '0; stride = '0; in_writedata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 128'(stall[0]), 128'(0));
    chk("rst_strobes", 128'({mread[0], mwrite[0], mread[1], mwrite[1]}), 128'(0));
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 128'({busy[0], busy[1]}), 128'(0));
    chk("rst_out0", rdout[0], 128'(0));
    chk("rst_out1", rdout[1], 128'(0));
    chk("idle_addr", 128'(maddr[0]), 128'(0));

    // Directed scenarios
    run_op(0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 128'h000000A3_000000A2_000000A1_000000A0);
    run_op(0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, '0);
    run_op(1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h40, '0);
    run_op(0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h40, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    run_op(0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, '0);
    run_op(1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h80, '0);
    run_op(0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, '0);
    run_op(1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FF00, 32'h60, 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1234_5678);

    // Reset in cycle 2 of a vector load
    @(posedge clk); #1;
    req_write = 1'b0; req_vector = 1'b1; req_strided = 1'b0;
    base_addr = 32'h300; stride = '0; req_valid[0] = 1'b1;
    @(negedge clk);
    chk("rst_mid_addr0", 128'(maddr[0]), 128'(32'h300));
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_addr1", 128'(maddr[0]), 128'(32'h304));
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_strobes", 128'({mread[0], mwrite[0]}), 128'(0));
    chk("rst_mid_stall", 128'(stall[0]), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0; req_valid[0] = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 128'(busy[0]), 128'(0));
    chk("rst_mid_out", rdout[0], 128'(0));
    chk("rst_mid_stall_after", 128'(stall[0]), 128'(0));
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_late_resp", rdout[0], 128'(0));
    run_op(0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 128'h44_0000_0033_0000_0022_0000_0011);

    // Random ops on both latencies
    for (int k = 0; k < 16; k++) begin
      run_op(int'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom, $urandom, {$urandom, $urandom, $urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
